usbf_sie_tx: RTL

//  USB device SIE transmit path: serialises one handshake (PID only) or data packet (PID, payload, CRC16) onto UTMI TX.

---
 rtl/usbf_sie_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/usbf_sie_tx.sv
// USB device SIE transmit path: PID-only or PID/payload/CRC16 packets
// onto the UTMI TX byte interface, with inter-packet gap enforcement.
module usbf_sie_tx #(
  parameter int unsigned IFS_CYCLES = 7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       rx_active_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_pid_i,
  output logic       tx_accept_o,
  input  logic       data_valid_i,
  input  logic       data_strb_i,
  input  logic [7:0] data_i,
  input  logic       data_last_i,
  output logic       data_accept_o,
  output logic [7:0] utmi_data_o,
  output logic       utmi_txvalid_o,
  input  logic       utmi_txready_i,
  output logic       busy_o,
  output logic       underrun_o
);

  localparam int IW =
    (IFS_CYCLES > 0) ? $clog2(IFS_CYCLES + 1) : 1;
  localparam logic [IW-1:0] IFS_LD = IW'(IFS_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI
  } state_t;

  function automatic logic [15:0] usbf_crc16(
    input logic [15:0] crc,
    input logic [7:0]  d
  );
    logic [15:0] c;
    c = crc ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ 16'hA001;
      else      c = c >> 1;
    end
    return c;
  endfunction

  state_t          state_q, state_d;
  logic [7:0]      pid_q, pid_d;
  logic [15:0]     crc_q, crc_d;
  logic [IW-1:0]   ifs_q, ifs_d;
  logic            pkt_end;
  logic            is_data;

  // DATA0/1/2/MDATA are exactly the PIDs whose low two bits are 11
  assign is_data = (pid_q[1:0] == 2'b11);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      pid_q   <= 8'h00;
      crc_q   <= 16'hFFFF;
      ifs_q   <= '0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      crc_q   <= crc_d;
      ifs_q   <= ifs_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pid_d          = pid_q;
    crc_d          = crc_q;
    tx_accept_o    = 1'b0;
    data_accept_o  = 1'b0;
    utmi_txvalid_o = 1'b0;
    utmi_data_o    = 8'h00;
    underrun_o     = 1'b0;
    pkt_end        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tx_valid_i && !rx_active_i &&
            (ifs_q == '0)) begin
          tx_accept_o = 1'b1;
          pid_d       = tx_pid_i;
          crc_d       = 16'hFFFF;
          state_d     = S_PID;
        end
      end
      S_PID: begin
        utmi_txvalid_o = 1'b1;
        utmi_data_o    = pid_q;
        if (utmi_txready_i) begin
          if (is_data) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
            pkt_end = 1'b1;
          end
        end
      end
      S_DATA: begin
        utmi_data_o    = data_i;
        utmi_txvalid_o = data_valid_i & data_strb_i;
        data_accept_o  = data_valid_i &
                         (utmi_txready_i | !data_strb_i);
        if (!data_valid_i) begin
          underrun_o = 1'b1;
          pkt_end    = 1'b1;
          state_d    = S_IDLE;
        end else if (data_strb_i) begin
          if (utmi_txready_i) begin
            crc_d = usbf_crc16(crc_q, data_i);
            if (data_last_i) state_d = S_CRC_LO;
          end
        end else if (data_last_i) begin
          state_d = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        utmi_txvalid_o = 1'b1;
        utmi_data_o    = ~crc_q[7:0];
        if (utmi_txready_i) state_d = S_CRC_HI;
      end
      S_CRC_HI: begin
        utmi_txvalid_o = 1'b1;
        utmi_data_o    = ~crc_q[15:8];
        if (utmi_txready_i) begin
          state_d = S_IDLE;
          pkt_end = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Disable aborts whatever is in flight and forgets the request
    if (!enable_i) begin
      state_d        = S_IDLE;
      tx_accept_o    = 1'b0;
      data_accept_o  = 1'b0;
      utmi_txvalid_o = 1'b0;
      underrun_o     = 1'b0;
      pkt_end        = 1'b0;
    end
  end

  always_comb begin
    ifs_d = ifs_q;
    if (!enable_i || rx_active_i || pkt_end) begin
      ifs_d = IFS_LD;
    end else if (ifs_q != '0) begin
      ifs_d = ifs_q - IW'(1);
    end
  end

  assign busy_o = (state_q != S_IDLE) || (ifs_q != '0);

endmodule
